fp_addsub_pipe: RTL and testbench

- Pipelined, parametrised IEEE-style floating-point adder/subtractor.
- It is the successor of the team's combinational 16-bit half-precision adder and uses the same exception encoding and the same flush-to-zero treatment of subnormals.
- Adds configurable exponent and mantissa width, per-transaction add/subtract mode, round-to-nearest-even with guard/round/sticky bits, and a valid/ready streaming handshake.
- Sits between operand-issue logic and the result writeback buffer in the FP datapath.

---
 rtl/fp_pkg.sv | 38 +++
 rtl/fp_norm_round.sv | 64 ++++++
 rtl/fp_addsub_pipe.sv | 162 ++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point adder/subtractor.
//   EXC_*       : 2-bit exception codes driven on out_exc
//   fp_stage_t  : per-stage payload; widths are sized for the widest format
//                 the block is expected to be built for (double precision),
//                 narrower formats use the low bits of each field
//   fp_qnan()   : canonical quiet NaN for a given exponent/fraction width
package fp_pkg;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_INF  = 2'b01;
  localparam logic [1:0] EXC_UFL  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  localparam int FP_EXP_MAX = 11;
  localparam int FP_MAN_MAX = 52;
  localparam int FP_PEW     = FP_EXP_MAX + 1;
  localparam int FP_PMW     = FP_MAN_MAX + 5;
  localparam int FP_WMAX    = 1 + FP_EXP_MAX + FP_MAN_MAX;

  // special=1 means {sign, exp, man} already holds the final result.
  typedef struct packed {
    logic              sign;
    logic [FP_PEW-1:0] exp;
    logic [FP_PMW-1:0] man;
    logic              special;
    logic [1:0]        exc;
  } fp_stage_t;

  // Sign 0, exponent all ones, fraction MSB set, rest zero.
  function automatic logic [FP_WMAX-1:0] fp_qnan(input int exp_w, input int man_w);
    logic [FP_WMAX-1:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) r[man_w+i] = 1'b1;
    r[man_w-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fp_norm_round.sv
// Normalise and round one mantissa sum (combinational).
//   sign    : result sign
//   exp_big : exponent of the larger operand (>= 1)
//   sum     : {carry, hidden, fraction, guard, round, sticky}
//   res/exc : packed result and exception code
module fp_norm_round
  import fp_pkg::*;
#(
  parameter  int EXP_W = 5,
  parameter  int MAN_W = 10,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic             sign,
  input  logic [EXP_W-1:0] exp_big,
  input  logic [MAN_W+4:0] sum,
  output logic [W-1:0]     res,
  output logic [1:0]       exc
);

  localparam int MW = MAN_W + 4;
  localparam int XW = EXP_W + 1;
  localparam logic [XW-1:0] ONE  = XW'(1);
  localparam logic [XW-1:0] EALL = {1'b0, {EXP_W{1'b1}}};

  logic [XW-1:0]    lzc, lim, sh, e_norm, e_fin;
  logic [MW-1:0]    m;
  logic [MAN_W+1:0] m_rnd;
  logic             rnd_up;

  always_comb begin
    lzc = XW'(MW);
    for (int i = 0; i < MW; i++)
      if (sum[i]) lzc = XW'(MW - 1 - i);
    // Never shift the exponent below 1; whatever stays unnormalised underflows.
    lim = {1'b0, exp_big} - ONE;
    sh  = '0;
    if (sum[MW]) begin
      m      = {sum[MW:2], sum[1] | sum[0]};
      e_norm = {1'b0, exp_big} + ONE;
    end else begin
      sh     = (lzc > lim) ? lim : lzc;
      m      = sum[MW-1:0] << sh;
      e_norm = {1'b0, exp_big} - sh;
    end
    // Nearest-even: up when guard set and (round|sticky|lsb).
    rnd_up = m[2] & (m[1] | m[0] | m[3]);
    m_rnd  = {1'b0, m[MW-1:3]} + (MAN_W+2)'(rnd_up);
    // A rounding carry leaves the fraction all zeros, so the low bits stay valid.
    e_fin  = e_norm + XW'(m_rnd[MAN_W+1]);

    res = {sign, e_fin[EXP_W-1:0], m_rnd[MAN_W-1:0]};
    exc = EXC_NONE;
    if (sum == '0) begin
      res = '0;
    end else if (!m[MW-1]) begin
      res = {sign, {(W-1){1'b0}}};
      exc = EXC_UFL;
    end else if (e_fin >= EALL) begin
      res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      exc = EXC_INF;
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor, RNE rounding,
// subnormals flushed to zero.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : operand handshake; in_a, in_b, in_sub (1 = A-B)
//   out_valid/out_ready  : result handshake; out_res, out_exc
// Stage 1 classifies and aligns, stage 2 adds/subtracts, stage 3 normalises
// and rounds into the output register. One global enable stalls everything.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter  int EXP_W = 5,
  parameter  int MAN_W = 10,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic [1:0]   out_exc
);

  localparam int STAGES = 2;
  localparam int MW     = MAN_W + 4;
  localparam logic [EXP_W-1:0]   EMAX   = '1;
  localparam logic [EXP_W-1:0]   SH_LIM = EXP_W'(MAN_W + 3);
  localparam logic [FP_WMAX-1:0] QNAN_F = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]       QNAN   = QNAN_F[W-1:0];

  logic [STAGES:0] vld_pipe;
  logic            en;

  assign out_valid = vld_pipe[STAGES];
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;

  // ---- stage 1: classify / align ----
  logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;
  logic [EXP_W-1:0] ea, eb, e_big, e_sm, d;
  logic [MAN_W-1:0] fa, fb;
  logic [MW-1:0]    m_big, m_raw, m_sh, m_lost, m_sm;
  fp_stage_t        p1;

  always_comb begin
    sa = in_a[W-1];
    sb = in_b[W-1] ^ in_sub;
    ea = in_a[W-2:MAN_W];
    eb = in_b[W-2:MAN_W];
    fa = in_a[MAN_W-1:0];
    fb = in_b[MAN_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == EMAX) && (fa == '0);
    b_inf  = (eb == EMAX) && (fb == '0);
    a_nan  = (ea == EMAX) && (fa != '0);
    b_nan  = (eb == EMAX) && (fb != '0);

    a_big = {ea, fa} >= {eb, fb};
    e_big = a_big ? ea : eb;
    e_sm  = a_big ? eb : ea;
    m_big = {1'b1, (a_big ? fa : fb), 3'b000};
    m_raw = {1'b1, (a_big ? fb : fa), 3'b000};
    d     = e_big - e_sm;
    {m_sh, m_lost} = {m_raw, {MW{1'b0}}} >> d;
    m_sm  = (d >= SH_LIM) ? {{(MW-1){1'b0}}, 1'b1}
                          : {m_sh[MW-1:1], m_sh[0] | (|m_lost)};

    p1      = '0;
    p1.sign = a_big ? sa : sb;
    p1.exp  = FP_PEW'(e_big);
    p1.man  = FP_PMW'(m_big);
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      p1.special = 1'b1;
      p1.sign    = QNAN[W-1];
      p1.exp     = FP_PEW'(QNAN[W-2:MAN_W]);
      p1.man     = FP_PMW'(QNAN[MAN_W-1:0]);
      p1.exc     = EXC_NAN;
    end else if (a_inf || b_inf) begin
      p1.special = 1'b1;
      p1.sign    = a_inf ? sa : sb;
      p1.exp     = FP_PEW'(EMAX);
      p1.man     = '0;
      p1.exc     = EXC_INF;
    end else if (a_zero && b_zero) begin
      p1.special = 1'b1;
      p1.sign    = sa & sb;
      p1.exp     = '0;
      p1.man     = '0;
    end else if (a_zero) begin
      p1.special = 1'b1;
      p1.sign    = sb;
      p1.exp     = FP_PEW'(eb);
      p1.man     = FP_PMW'(fb);
    end else if (b_zero) begin
      p1.special = 1'b1;
      p1.sign    = sa;
      p1.exp     = FP_PEW'(ea);
      p1.man     = FP_PMW'(fa);
    end
  end

  fp_stage_t     s1_q, s2_q, s2_d;
  logic [MW-1:0] s1_sm_q;
  logic          s1_sub_q;

  // ---- stage 2: add / subtract (big >= small, so no negative result) ----
  logic [MW:0] sum2;

  always_comb begin
    s2_d = s1_q;
    sum2 = s1_sub_q ? ({1'b0, s1_q.man[MW-1:0]} - {1'b0, s1_sm_q})
                    : ({1'b0, s1_q.man[MW-1:0]} + {1'b0, s1_sm_q});
    if (!s1_q.special) s2_d.man = FP_PMW'(sum2);
  end

  // ---- stage 3: normalise / round ----
  logic [W-1:0] nr_res, res3;
  logic [1:0]   nr_exc, exc3;

  fp_norm_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_norm (
    .sign    (s2_q.sign),
    .exp_big (s2_q.exp[EXP_W-1:0]),
    .sum     (s2_q.man[MW:0]),
    .res     (nr_res),
    .exc     (nr_exc)
  );

  always_comb begin
    res3 = nr_res;
    exc3 = nr_exc;
    if (s2_q.special) begin
      res3 = {s2_q.sign, s2_q.exp[EXP_W-1:0], s2_q.man[MAN_W-1:0]};
      exc3 = s2_q.exc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s1_sm_q  <= '0;
      s1_sub_q <= 1'b0;
      s2_q     <= '0;
      out_res  <= '0;
      out_exc  <= EXC_NONE;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
      s1_q     <= p1;
      s1_sm_q  <= m_sm;
      s1_sub_q <= sa ^ sb;
      s2_q     <= s2_d;
      out_res  <= res3;
      out_exc  <= exc3;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: half precision instance plus a
// single precision instance for the parameterised build.
module tb_fp_addsub_pipe;

  logic        clk, rst_n;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [15:0] in_a, in_b, out_res;
  logic [1:0]  out_exc;

  logic        p_valid, p_ready, p_sub, p_ovalid, p_oready;
  logic [31:0] p_a, p_b, p_res;
  logic [1:0]  p_exc;

  int total = 0;
  int bad   = 0;

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_exc(out_exc)
  );

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(p_valid), .in_ready(p_ready),
    .in_a(p_a), .in_b(p_b), .in_sub(p_sub),
    .out_valid(p_ovalid), .out_ready(p_oready),
    .out_res(p_res), .out_exc(p_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Single transaction on the half-precision DUT; pipeline idle, out_ready=1.
  task automatic xact(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic sub, input logic [15:0] er, input logic [1:0] ee);
    int n;
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk({tag, "_lat"}, 32'(n), 32'd3);
    chk({tag, "_res"}, 32'(out_res), 32'(er));
    chk({tag, "_exc"}, 32'(out_exc), 32'(ee));
  endtask

  logic [15:0] bp_a [8];
  logic [15:0] bp_e [8];
  int sent, got, cyc, n32;
  logic xin, xout;

  initial begin
    bp_a = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800};
    bp_e = '{16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800, 16'h4880};
    rst_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0;
    p_valid = 1'b0; p_sub = 1'b0; p_oready = 1'b1; p_a = '0; p_b = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_res", 32'(out_res), 32'd0);
    chk("rst_exc", 32'(out_exc), 32'd0);
    chk("rst_vld32", 32'(p_ovalid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_vld_after", 32'(out_valid), 32'd0);

    xact("one_plus_two", 16'h3C00, 16'h4000, 1'b0, 16'h4200, 2'b00);
    xact("cancel",       16'h3C00, 16'h3C00, 1'b1, 16'h0000, 2'b00);
    xact("tie_even",     16'h3C00, 16'h1000, 1'b0, 16'h3C00, 2'b00);
    xact("tie_up",       16'h3C01, 16'h1000, 1'b0, 16'h3C02, 2'b00);
    xact("overflow",     16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 2'b01);
    xact("inf_minf",     16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 2'b11);
    xact("nan_in",       16'h7C01, 16'h3C00, 1'b0, 16'h7E00, 2'b11);
    xact("underflow",    16'h0401, 16'h0400, 1'b1, 16'h0000, 2'b10);
    xact("neg_zeros",    16'h8000, 16'h0000, 1'b1, 16'h8000, 2'b00);
    xact("zero_plus_b",  16'h0000, 16'h4000, 1'b1, 16'hC000, 2'b00);

    // Back-pressure stream: out_ready pattern 1,0,0,1 repeating.
    @(posedge clk); #1;
    sent = 0; got = 0; cyc = 0;
    while (got < 8 && cyc < 100) begin
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = (sent < 8);
      if (sent < 8) in_a = bp_a[sent];
      in_b = 16'h3C00; in_sub = 1'b0;
      #1;
      chk("bp_rdy", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid) chk("bp_res", 32'(out_res), 32'(bp_e[got]));
      xin  = in_valid && in_ready;
      xout = out_valid && out_ready;
      @(posedge clk); #1;
      if (xin) sent++;
      if (xout) got++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_sent", 32'(sent), 32'd8);
    chk("bp_got", 32'(got), 32'd8);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_nodup", 32'(out_valid), 32'd0);
    end

    // Reset with three transactions in flight.
    repeat (3) begin
      in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h4000; in_sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_res", 32'(out_res), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst_idle", 32'(out_valid), 32'd0);
    end
    xact("post_rst", 16'h3C00, 16'h4000, 1'b0, 16'h4200, 2'b00);

    // Single precision instance.
    p_a = 32'h3F800000; p_b = 32'h40000000; p_sub = 1'b0; p_valid = 1'b1;
    @(posedge clk); #1;
    p_valid = 1'b0;
    n32 = 1;
    while (!p_ovalid && n32 < 10) begin @(posedge clk); #1; n32++; end
    chk("sp_lat", 32'(n32), 32'd3);
    chk("sp_res", p_res, 32'h40400000);
    chk("sp_exc", 32'(p_exc), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
